j_chunk_fetcher: RTL and testbench



---
 rtl/j_chunk_fetcher.sv | 142 ++++++++++++++
 tb/tb_j_chunk_fetcher.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/j_chunk_fetcher.sv
// J-matrix chunk fetcher: streams NUM_J_CHUNKS sequential J-memory reads
// through a small in-order FIFO to the MatMul energy stage.
// Reads are issued only against free FIFO credits, so a response always has
// a slot waiting for it. A slot that is being drained in the current cycle
// also counts as free, which keeps the stream at one chunk per cycle with a
// two-entry FIFO.
module j_chunk_fetcher #(
    parameter int MEM_BANDWIDTH   = 4096,
    parameter int VECTOR_SIZE     = 256,
    parameter int J_ELEMENT_WIDTH = 4,
    parameter int ADDR_WIDTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int FIFO_DEPTH      = 2,
    localparam int J_COLS_PER_READ = MEM_BANDWIDTH / (VECTOR_SIZE * J_ELEMENT_WIDTH),
    localparam int NUM_J_CHUNKS    = VECTOR_SIZE / J_COLS_PER_READ,
    localparam int IDX_W           = $clog2(NUM_J_CHUNKS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_req,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [MEM_BANDWIDTH-1:0] mem_rdata,
    output logic                     chunk_valid,
    input  logic                     chunk_ready,
    output logic [MEM_BANDWIDTH-1:0] chunk_data,
    output logic [IDX_W-1:0]         chunk_idx,
    output logic                     chunk_last
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int REQ_W = IDX_W + 1;

    // state | meaning
    // IDLE  | waiting for start, no requests
    // FETCH | issuing reads while credits remain, until all chunks granted
    // DRAIN | all reads granted, waiting for the last chunk handshake
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                   state;
    logic [REQ_W-1:0]         req_cnt;
    logic [IDX_W-1:0]         out_cnt;
    logic [CNT_W-1:0]         outstanding;
    logic [CNT_W-1:0]         fifo_count;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [MEM_BANDWIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [CNT_W:0]           used;
    logic                     grant;
    logic                     push;
    logic                     pop;
    logic                     last_pop;

    assign used     = {1'b0, fifo_count} + {1'b0, outstanding};
    assign grant    = mem_req && mem_gnt;
    assign push     = mem_rvalid && (outstanding != '0);
    assign pop      = chunk_valid && chunk_ready;
    assign last_pop = pop && (out_cnt == IDX_W'(NUM_J_CHUNKS - 1));

    // Credit check only ever grows between grants, so a pending request holds.
    assign mem_req  = (state == FETCH)
                   && (req_cnt < REQ_W'(NUM_J_CHUNKS))
                   && ((used < (CNT_W + 1)'(FIFO_DEPTH)) || pop);
    assign mem_addr = BASE_ADDR + ADDR_WIDTH'(req_cnt);

    assign busy        = (state != IDLE);
    assign chunk_valid = (fifo_count != '0);
    assign chunk_data  = fifo_mem[rd_ptr];
    assign chunk_idx   = out_cnt;
    assign chunk_last  = (out_cnt == IDX_W'(NUM_J_CHUNKS - 1));

    // Pass sequencing and the done pulse one cycle after the final handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE:  if (start) state <= FETCH;
                FETCH: if (grant && (req_cnt == REQ_W'(NUM_J_CHUNKS - 1))) state <= DRAIN;
                DRAIN: if (last_pop) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request, output-index and in-flight counters; cleared when a pass starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt     <= '0;
            out_cnt     <= '0;
            outstanding <= '0;
        end else if ((state == IDLE) && start) begin
            req_cnt     <= '0;
            out_cnt     <= '0;
            outstanding <= '0;
        end else begin
            if (grant) req_cnt <= req_cnt + REQ_W'(1);
            if (pop)   out_cnt <= out_cnt + IDX_W'(1);
            case ({grant, push})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // In-order response buffer; the head entry drives chunk_data directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= mem_rdata;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // A response with nothing in flight means the memory returned an unrequested word.
    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_rvalid && (outstanding == '0)));

endmodule

// File: tb/tb_j_chunk_fetcher.sv
// Bench for j_chunk_fetcher: memory model with configurable grant/latency,
// consumer with configurable backpressure, expected-chunk scoreboard and
// an independent monitor.
module tb_j_chunk_fetcher;

    localparam int MW         = 4096;
    localparam int NCH        = 64;
    localparam logic [15:0] BASE = 16'h0100;
    localparam int PASS_LIMIT = 600;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          mem_req;
    logic [15:0]   mem_addr;
    logic          mem_gnt = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [MW-1:0] mem_rdata = '0;
    logic          chunk_valid;
    logic          chunk_ready = 1'b0;
    logic [MW-1:0] chunk_data;
    logic [5:0]    chunk_idx;
    logic          chunk_last;

    typedef struct { logic [MW-1:0] data; int idx; bit last; } exp_t;
    typedef struct { int due; logic [15:0] addr; } rsp_t;

    exp_t          exp_q[$];
    rsp_t          pipe_q[$];
    logic [MW-1:0] jmem [NCH];

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     start_cyc = -1000;
    int     start_pend = 0;
    int     ready_mode = 0;
    int     gnt_mode = 0;
    int     lat = 1;
    int     grant_cnt = 0;
    int     drv_pops = 0;
    int     hs_cnt = 0;
    int     pass_done = 0;
    int     total_done = 0;
    int     passes_done = 0;
    int     last_hs_cyc = 0;
    bit     first_req_seen = 1'b1;
    bit     energy_on = 1'b0;
    longint energy = 0;

    j_chunk_fetcher #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .chunk_valid(chunk_valid), .chunk_ready(chunk_ready),
        .chunk_data(chunk_data), .chunk_idx(chunk_idx), .chunk_last(chunk_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic summary();
        $display("test done: total=%0d bad=%0d", total, bad);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_addr"}, mem_addr, BASE);
        chk({tag, "_chunk_valid"}, chunk_valid, 0);
        chk({tag, "_chunk_idx"}, chunk_idx, 0);
        chk({tag, "_chunk_last"}, chunk_last, 0);
        total++;
        if (chunk_data !== '0) begin
            bad++;
            $display("FAIL %s_chunk_data: got_lo=%h want 0", tag, chunk_data[63:0]);
        end
    endtask

    // kind 0: every nibble = chunk index mod 16; 1: random; 2: all J = 15
    task automatic fill(input int kind);
        logic [3:0] nib;
        for (int k = 0; k < NCH; k++) begin
            nib = 4'(k);
            case (kind)
                0: jmem[k] = {1024{nib}};
                2: jmem[k] = {1024{4'hF}};
                default: for (int w = 0; w < MW / 32; w++) jmem[k][w*32 +: 32] = $urandom;
            endcase
        end
    endtask

    task automatic begin_pass(input int rm, input int gm, input int l, input int kind);
        ready_mode = rm;
        gnt_mode   = gm;
        lat        = l;
        fill(kind);
        exp_q.delete();
        for (int k = 0; k < NCH; k++) exp_q.push_back('{jmem[k], k, (k == NCH - 1)});
        grant_cnt  = 0;
        drv_pops   = 0;
        hs_cnt     = 0;
        pass_done  = 0;
        start_pend = 1;
    endtask

    task automatic finish_pass(input string tag, input bit check_busy);
        int n = 0;
        while (pass_done == 0 && n < PASS_LIMIT) begin
            @(negedge clk); #3;
            n++;
            if (check_busy && n == 2) chk({tag, "_busy_in_pass"}, busy, 1);
        end
        if (pass_done == 0) begin
            total++; bad++;
            $display("FAIL %s_timeout: no done after %0d cycles", tag, n);
            summary();
            $finish;
        end
        passes_done++;
        chk({tag, "_handshakes"}, hs_cnt, NCH);
        chk({tag, "_grants"}, grant_cnt, NCH);
        chk({tag, "_exp_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_cnt < target && n < PASS_LIMIT) begin
            @(negedge clk); #3;
            n++;
        end
        if (hs_cnt < target) begin
            total++; bad++;
            $display("FAIL wait_hs_timeout: got %0d handshakes want %0d", hs_cnt, target);
            summary();
            $finish;
        end
    endtask

    // Memory and consumer driver: inputs change on the falling edge only.
    initial begin
        bit          pop_now;
        bit          prev_wait;
        logic [15:0] prev_addr;
        int          off;
        prev_wait = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pipe_q.delete();
                start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; chunk_ready = 1'b0;
                prev_wait = 1'b0;
                continue;
            end
            start = (start_pend != 0);
            if (start_pend == 1) begin
                start_cyc      = cyc;
                first_req_seen = 1'b0;
            end
            start_pend = 0;
            case (ready_mode)
                0: chunk_ready = 1'b1;
                1: chunk_ready = !((cyc - start_cyc) >= 5 && (cyc - start_cyc) <= 20);
                default: chunk_ready = ($urandom_range(3) != 0);
            endcase
            case (gnt_mode)
                0: mem_gnt = 1'b1;
                1: mem_gnt = (cyc % 2 == 0);
                default: mem_gnt = ($urandom_range(9) < 7);
            endcase
            if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                off = int'(pipe_q[0].addr) - int'(BASE);
                if (off >= 0 && off < NCH) mem_rdata = jmem[off];
                else mem_rdata = '0;
                void'(pipe_q.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                for (int w = 0; w < MW / 32; w++) mem_rdata[w*32 +: 32] = $urandom;
            end
            #1;
            pop_now = chunk_valid && chunk_ready;
            if (mem_req && !first_req_seen) begin
                chk("first_req_latency", cyc - start_cyc, 1);
                first_req_seen = 1'b1;
            end
            if (prev_wait) begin
                chk("req_hold", mem_req, 1);
                chk("addr_hold", mem_addr, prev_addr);
            end
            if (mem_req && !pop_now) chk("credit_limit", (grant_cnt - drv_pops) < 2, 1);
            if (mem_req && mem_gnt) begin
                chk("grant_addr", mem_addr, int'(BASE) + grant_cnt);
                pipe_q.push_back('{cyc + lat, mem_addr});
                grant_cnt++;
            end
            if (pop_now) drv_pops++;
            prev_wait = mem_req && !mem_gnt;
            prev_addr = mem_addr;
        end
    end

    // Monitor: pops the scoreboard on every chunk handshake.
    initial begin
        bit            prev_stall;
        logic [MW-1:0] prev_data;
        logic [5:0]    prev_idx;
        exp_t          e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_idx   = '0;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (done) begin
                total_done++;
                pass_done++;
                chk("busy_at_done", busy, 0);
                chk("hs_before_done", hs_cnt, NCH);
            end
            if (prev_stall) begin
                chk("stall_valid", chunk_valid, 1);
                chk("stall_idx", chunk_idx, prev_idx);
                total++;
                if (chunk_data !== prev_data) begin
                    bad++;
                    $display("FAIL stall_data: got_lo=%h want_lo=%h", chunk_data[63:0], prev_data[63:0]);
                end
            end
            if (chunk_valid && chunk_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_chunk: got idx %0d, none expected", chunk_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("chunk_idx", chunk_idx, e.idx);
                    chk("chunk_last", chunk_last, e.last);
                    total++;
                    if (chunk_data !== e.data) begin
                        bad++;
                        $display("FAIL chunk_data idx %0d: got_lo=%h want_lo=%h",
                                 e.idx, chunk_data[63:0], e.data[63:0]);
                    end
                end
                if (energy_on)
                    for (int i = 0; i < MW / 4; i++) energy += longint'(chunk_data[i*4 +: 4]);
                hs_cnt++;
                last_hs_cyc = cyc;
            end
            prev_stall = chunk_valid && !chunk_ready;
            prev_data  = chunk_data;
            prev_idx   = chunk_idx;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        summary();
        $fatal(1, "watchdog");
    end

    // Test sequence.
    initial begin
        longint golden;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check_reset_vals("por");
        @(negedge clk); #2 rst_n = 1'b1; #1;

        // ideal memory, full-rate consumer
        begin_pass(0, 0, 1, 0);
        finish_pass("ideal", 1'b1);
        chk("ideal_pass_within_68", (last_hs_cyc - start_cyc) <= 68, 1);

        // consumer backpressure in pass cycles 5..20
        begin_pass(1, 0, 1, 1);
        finish_pass("backpressure", 1'b1);

        // toggling grant, 3-cycle response latency
        begin_pass(2, 1, 3, 1);
        finish_pass("slow_mem", 1'b1);

        // start during a pass is ignored; next pass starts one cycle after done
        begin_pass(2, 2, 2, 1);
        wait_hs(10);
        start_pend = 2;
        finish_pass("b2b_first", 1'b0);
        begin_pass(0, 0, 1, 1);
        finish_pass("b2b_second", 1'b1);

        // asynchronous reset after chunk 30 has been accepted
        begin_pass(2, 2, 2, 1);
        wait_hs(31);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1; #1;
        begin_pass(2, 2, 2, 1);
        finish_pass("after_reset", 1'b1);

        // end-to-end: all J = 15, sigma all +1
        energy    = 0;
        energy_on = 1'b1;
        begin_pass(2, 0, 1, 2);
        finish_pass("energy", 1'b1);
        energy_on = 1'b0;
        golden = longint'(2 * 256 - 256) * longint'(2 * 256 - 256) * 15;
        chk("energy", energy, golden);

        // fully random passes
        for (int p = 0; p < 3; p++) begin
            begin_pass(2, 2, $urandom_range(4, 1), 1);
            finish_pass("random", 1'b1);
        end

        repeat (4) @(negedge clk);
        #3;
        chk("done_pulses", total_done, passes_done);
        chk("idle_busy", busy, 0);
        summary();
        $finish;
    end

endmodule
